alu_seq_w: RTL and testbench
============================

Name: alu_seq_w

Overview:
- Parametrised W-bit ALU built from the team's bit-slice ALU semantics: operand invert controls, carry-in from b_invert, and AND/OR/ADD/SLT select.
- Adds registered outputs, status flags and a correct signed SLT.
- Adds an iterative shift-add multiply op with a start/busy/done handshake.
- Sits in the datapath between the register-file read ports and the writeback mux. The control FSM drives start and waits on done.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 4..64.
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL; 101-111 reserved
- a_invert  input  1  use ~a as operand A
- b_invert  input  1  use ~b as operand B; also sets carry-in to 1
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b
- result  output  WIDTH  registered result, held until next accepted op
- zero  output  1  registered (result == 0)
- co  output  1  registered carry-out of the adder (ADD/SLT), else 0
- overflow  output  1  registered signed overflow (ADD/SLT), else 0
- busy  output  1  high while a MUL is iterating
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n low, async) forces:
  - state = IDLE
  - result, zero, co, overflow, busy, done = 0
  - counter and internal accumulators = 0
- Reset mid-MUL aborts the operation; no done pulse is produced.
- Operand preparation:
  - A = a_invert ? ~a : a
  - B = b_invert ? ~b : b
  - ci = b_invert
  - {co, sum} = A + B + ci, computed WIDTH+1 bits wide
  - overflow = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1])
- Op results:
  - AND/OR: A & B, A | B.
  - ADD: sum.
  - SLT: result = {W-1 zeros, sum[W-1] ^ overflow}; co and overflow still reported. Subtract semantics require b_invert = 1.
  - Reserved ops: result 0, done pulses normally.
- States: IDLE, MUL.
- IDLE with start = 1 at edge E0:
  - Non-MUL op: result and flags written at E0, done = 1 for the following cycle, state stays IDLE. Latency 1.
  - MUL: latch A into a multiplicand register (shifting left), latch B into a multiplier register (shifting right), clear product and counter, busy = 1, go to MUL.
- MUL, each edge:
  - If multiplier[0] = 1, product += multiplicand, modulo 2^WIDTH.
  - Shift multiplicand left and multiplier right; counter++.
  - At the edge where counter reaches WIDTH (edge E_WIDTH): write result = product (low WIDTH bits, unsigned), set zero, co = 0, overflow = 0, busy = 0, done = 1, return to IDLE.
- Handshake:
  - start is ignored while busy. No queueing; inputs may change freely during MUL.
  - done pulses exactly one cycle per accepted op.
  - start asserted in the done cycle is accepted, since state is IDLE then.
  - op, a, b, a_invert and b_invert are sampled only at the accepting edge.
- Outputs are purely registered; no combinational path from any input to any output.

Test Plan:
- WIDTH=8, ADD a=0x7F, b=0x01: done after 1 cycle; result=0x80, overflow=1, co=0, zero=0.
- WIDTH=8, SLT with b_invert=1, a=0x80 (-128), b=0x01: result=0x01 (sign^overflow correct, raw sum bit would give 0); a=0x05, b=0x03 gives result=0x00.
- WIDTH=8, ADD with b_invert=1, a=0x05, b=0x05: result=0x00, zero=1, co=1.
- WIDTH=8, MUL a=7, b=6: busy high for 8 cycles, done pulses once at E8, result=42 (0x2A). Then MUL a=0xFF, b=0xFF: result=0x01.
- MUL in flight, start pulsed with ADD at cycle 3: ignored, MUL result intact. New start in the done cycle is accepted, and its done follows one cycle later.
- rst_n dropped at cycle 4 of MUL: busy, done and result go to 0 asynchronously; after release, no spurious done and IDLE accepts a new op.

Source files
------------

// File: rtl/alu_seq_w.sv
// W-bit ALU with registered results and flags, signed SLT, and an iterative
// shift-add multiply behind a start/busy/done handshake.
module alu_seq_w #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             co,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] opa_c, opb_c, sum_c;
  logic             add_co_c, add_ovf_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_co_c, alu_ovf_c;
  logic [WIDTH-1:0] prod_nxt_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Operand preparation and the shared W+1-bit adder.
  always_comb begin
    opa_c = a_invert ? ~a : a;
    opb_c = b_invert ? ~b : b;
    {add_co_c, sum_c} = SUM_W'(opa_c) + SUM_W'(opb_c) + SUM_W'(b_invert);
    add_ovf_c = (opa_c[WIDTH-1] == opb_c[WIDTH-1]) &&
                (sum_c[WIDTH-1] != opa_c[WIDTH-1]);
  end

  // Single-cycle op results; SLT uses the true sign (sum MSB xor overflow).
  always_comb begin
    alu_res_c = '0;
    alu_co_c  = 1'b0;
    alu_ovf_c = 1'b0;
    case (op)
      OP_AND: alu_res_c = opa_c & opb_c;
      OP_OR:  alu_res_c = opa_c | opb_c;
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_co_c  = add_co_c;
        alu_ovf_c = add_ovf_c;
      end
      OP_SLT: begin
        alu_res_c = WIDTH'(sum_c[WIDTH-1] ^ add_ovf_c);
        alu_co_c  = add_co_c;
        alu_ovf_c = add_ovf_c;
      end
      default: alu_res_c = '0;
    endcase
  end

  // One shift-add multiply step.
  always_comb begin
    prod_nxt_c = prod_q + (mplier_q[0] ? mcand_q : '0);
    cnt_nxt_c  = cnt_q + CNT_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = opa_c;
            mplier_d = opb_c;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res_c;
            zero_d   = (alu_res_c == '0);
            co_d     = alu_co_c;
            ovf_d    = alu_ovf_c;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_nxt_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_nxt_c;
        if (cnt_nxt_c == CNT_W'(WIDTH)) begin
          result_d = prod_nxt_c;
          zero_d   = (prod_nxt_c == '0);
          co_d     = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign co       = co_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_seq_w.sv
// Randomized self-checking bench for alu_seq_w at WIDTH=8 against an
// integer-arithmetic reference model.
module tb_alu_seq_w;

  localparam int unsigned TW = 8;
  localparam int MASK = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic          a_invert, b_invert;
  logic [TW-1:0] a, b;
  logic [TW-1:0] result;
  logic          zero, co, overflow, busy, done;

  int checks   = 0;
  int failures = 0;

  alu_seq_w #(.WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_invert(a_invert), .b_invert(b_invert), .a(a), .b(b),
    .result(result), .zero(zero), .co(co), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the prepared operands.
  task automatic model(input logic [2:0] o, input logic ai, input logic bi,
                       input logic [TW-1:0] av, input logic [TW-1:0] bv,
                       output logic [TW-1:0] r, output logic z,
                       output logic c, output logic v);
    logic [TW-1:0] ta, tb;
    int ua, ub, sa, sb, s, ss, rr;
    ta = ai ? ~av : av;
    tb = bi ? ~bv : bv;
    ua = int'(ta);
    ub = int'(tb);
    sa = (ua >= (1 << (TW - 1))) ? ua - (1 << TW) : ua;
    sb = (ub >= (1 << (TW - 1))) ? ub - (1 << TW) : ub;
    s  = ua + ub + int'(bi);
    ss = sa + sb + int'(bi);
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: rr = ua & ub;
      3'd1: rr = ua | ub;
      3'd2: begin
        rr = s & MASK;
        c  = (s > MASK);
        v  = (ss > (1 << (TW - 1)) - 1) || (ss < -(1 << (TW - 1)));
      end
      3'd3: begin
        rr = (ss < 0) ? 1 : 0;
        c  = (s > MASK);
        v  = (ss > (1 << (TW - 1)) - 1) || (ss < -(1 << (TW - 1)));
      end
      3'd4: rr = (ua * ub) & MASK;
      default: rr = 0;
    endcase
    r = TW'(rr);
    z = (rr == 0);
  endtask

  // Issue one op, wait (bounded) for done, check outputs and pulse width.
  task automatic run_op(input string tag, input logic [2:0] o, input logic ai,
                        input logic bi, input logic [TW-1:0] av, input logic [TW-1:0] bv);
    logic [TW-1:0] er;
    logic ez, ec, ev;
    int lat, busy_bad;
    model(o, ai, bi, av, bv, er, ez, ec, ev);
    @(negedge clk);
    op = o; a_invert = ai; b_invert = bi; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = TW'($urandom); b = TW'($urandom);
    a_invert = 1'($urandom); b_invert = 1'($urandom);
    lat = 0;
    busy_bad = 0;
    while (!done && lat < 4 * TW) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), (o == 3'd4) ? 64'(TW) : 64'd0);
    check_eq({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    check_eq({tag, " result"}, 64'(result), 64'(er));
    check_eq({tag, " zero"}, 64'(zero), 64'(ez));
    check_eq({tag, " co"}, 64'(co), 64'(ec));
    check_eq({tag, " overflow"}, 64'(overflow), 64'(ev));
    check_eq({tag, " busy_end"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, dcount;
    rst_n = 1'b0; start = 1'b0; op = '0; a_invert = 1'b0; b_invert = 1'b0;
    a = '0; b = '0;
    #3;
    check_eq("reset result", 64'(result), 64'd0);
    check_eq("reset flags", 64'({zero, co, overflow, busy, done}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", 3'd2, 1'b0, 1'b0, 8'h7F, 8'h01);
    run_op("slt_neg", 3'd3, 1'b0, 1'b1, 8'h80, 8'h01);
    run_op("slt_pos", 3'd3, 1'b0, 1'b1, 8'h05, 8'h03);
    run_op("sub_zero", 3'd2, 1'b0, 1'b1, 8'h05, 8'h05);
    run_op("and", 3'd0, 1'b0, 1'b0, 8'hF0, 8'h3C);
    run_op("or_inv", 3'd1, 1'b1, 1'b0, 8'hF0, 8'h03);
    run_op("rsvd", 3'd6, 1'b0, 1'b0, 8'h12, 8'h34);
    run_op("mul_42", 3'd4, 1'b0, 1'b0, 8'd7, 8'd6);
    run_op("mul_ff", 3'd4, 1'b0, 1'b0, 8'hFF, 8'hFF);

    // start during MUL is ignored; start in the done cycle is accepted
    @(negedge clk);
    op = 3'd4; a = 8'd7; b = 8'd6; a_invert = 1'b0; b_invert = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    op = 3'd2; a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    check_eq("ign done", 64'(done), 64'd0);
    check_eq("ign busy", 64'(busy), 64'd1);
    while (!done && lat < 4 * TW) begin @(posedge clk); #1; lat++; end
    check_eq("ign latency", 64'(lat), 64'(TW));
    check_eq("ign result", 64'(result), 64'd42);
    @(negedge clk);
    op = 3'd2; a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b done", 64'(done), 64'd1);
    check_eq("b2b result", 64'(result), 64'h33);
    check_eq("b2b busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_eq("b2b pulse", 64'(done), 64'd0);

    // async reset in the middle of a MUL
    run_op("pre_rst", 3'd2, 1'b0, 1'b0, 8'h10, 8'h20);
    @(negedge clk);
    op = 3'd4; a = 8'd3; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (2 * TW) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check_eq("rst no_spurious", 64'(dcount), 64'd0);
    run_op("post_rst_mul", 3'd4, 1'b0, 1'b0, 8'd9, 8'd9);

    for (int i = 0; i < 150; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), TW'($urandom), TW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
